// File: rtl/led_bar_decoder.sv
// Bouncing LED bar decoder: samples a bar display on strobe, tracks head position,
// direction and bounces, and flags out-of-sequence frames. Option: LED_BAR_DECODER_LATE_TURNAROUND_EN.
module led_bar_decoder #(
    parameter int SCREEN_WIDTH = 8,
    parameter int BAR_WIDTH    = 3,
    parameter int COUNT_WIDTH  = 8,
    localparam int POS_W       = $clog2(SCREEN_WIDTH + BAR_WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample,
    input  logic [SCREEN_WIDTH-1:0] screen,
    output logic [POS_W-1:0]        position,
    output logic                    direction,
    output logic                    locked,
    output logic                    frame_error,
    output logic [COUNT_WIDTH-1:0]  bounce_count,
    output logic [1:0]              state_dbg
);

    localparam int IDX_W = (SCREEN_WIDTH > 2) ? $clog2(SCREEN_WIDTH) : 1;
    localparam int LEN_W = $clog2(SCREEN_WIDTH + 1);

`ifdef LED_BAR_DECODER_LATE_TURNAROUND_EN
    localparam logic [POS_W-1:0] T_MIN = '0;
    localparam logic [POS_W-1:0] T_MAX = POS_W'(SCREEN_WIDTH + BAR_WIDTH - 2);
`else
    localparam logic [POS_W-1:0] T_MIN = POS_W'(BAR_WIDTH - 1);
    localparam logic [POS_W-1:0] T_MAX = POS_W'(SCREEN_WIDTH - 1);
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [POS_W-1:0]       pos_q, pos_d;
    logic                   dir_q, dir_d;
    logic                   locked_q, locked_d;
    logic                   err_q, err_d;
    logic [COUNT_WIDTH-1:0] bcnt_q, bcnt_d;

    logic [IDX_W-1:0] run_lo, run_hi;
    logic [LEN_W-1:0] run_len;
    logic             run_seen, run_contig;
    logic             frame_legal;
    logic [POS_W-1:0] frame_t;
    logic [POS_W-1:0] exp_t;
    logic             exp_dir;

    always_comb begin
        run_lo   = '0;
        run_hi   = '0;
        run_len  = '0;
        run_seen = 1'b0;
        for (int i = 0; i < SCREEN_WIDTH; i++) begin
            if (screen[i]) begin
                if (!run_seen) run_lo = IDX_W'(i);
                run_hi   = IDX_W'(i);
                run_len  = run_len + LEN_W'(1);
                run_seen = 1'b1;
            end
        end
    end

    // A single run is contiguous exactly when its span equals its population.
    assign run_contig = (int'(run_hi) - int'(run_lo) + 1) == int'(run_len);

    always_comb begin
        frame_legal = 1'b0;
        frame_t     = '0;
        if (run_seen && run_contig) begin
            if (int'(run_len) == BAR_WIDTH) begin
                frame_legal = 1'b1;
                frame_t     = POS_W'(run_hi);
            end
`ifdef LED_BAR_DECODER_LATE_TURNAROUND_EN
            else if (int'(run_len) < BAR_WIDTH && int'(run_lo) == 0) begin
                frame_legal = 1'b1;
                frame_t     = POS_W'(run_len) - POS_W'(1);
            end else if (int'(run_len) < BAR_WIDTH && int'(run_hi) == SCREEN_WIDTH - 1) begin
                frame_legal = 1'b1;
                frame_t     = POS_W'(SCREEN_WIDTH - 1 + BAR_WIDTH) - POS_W'(run_len);
            end
`endif
        end
    end

    always_comb begin
        exp_dir = dir_q;
        exp_t   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        if (pos_q == T_MAX) begin
            exp_t   = pos_q - POS_W'(1);
            exp_dir = 1'b0;
        end else if (pos_q == T_MIN) begin
            exp_t   = pos_q + POS_W'(1);
            exp_dir = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        err_d   = 1'b0;
        bcnt_d  = bcnt_q;
        if (sample) begin
            if (!frame_legal) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d = SYNC;
                        pos_d   = frame_t;
                    end
                    SYNC: begin
                        if (frame_t == pos_q) begin
                            state_d = SYNC;
                        end else if (frame_t == pos_q + POS_W'(1) || frame_t == pos_q - POS_W'(1)) begin
                            state_d = LOCKED;
                            pos_d   = frame_t;
                            dir_d   = frame_t > pos_q;
                        end else begin
                            pos_d = frame_t;
                            err_d = 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (frame_t == pos_q) begin
                            state_d = LOCKED;
                        end else if (frame_t == exp_t) begin
                            pos_d = frame_t;
                            dir_d = exp_dir;
                            if (exp_dir != dir_q) bcnt_d = bcnt_q + COUNT_WIDTH'(1);
                        end else begin
                            state_d = SYNC;
                            pos_d   = frame_t;
                            err_d   = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pos_q    <= '0;
            dir_q    <= 1'b1;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            bcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            bcnt_q   <= bcnt_d;
        end
    end

    assign position     = pos_q;
    assign direction    = dir_q;
    assign locked       = locked_q;
    assign frame_error  = err_q;
    assign bounce_count = bcnt_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_led_bar_decoder.sv
// Scoreboard bench for led_bar_decoder; expectations follow the build's
// LED_BAR_DECODER_LATE_TURNAROUND_EN setting.
module tb_led_bar_decoder;

    localparam int SW = 8;
    localparam int BW = 3;
    localparam int CW = 8;
    localparam int PW = 4;
    localparam int W  = PW + 3 + CW;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample;
    logic [SW-1:0] screen;
    logic [PW-1:0] position;
    logic          direction;
    logic          locked;
    logic          frame_error;
    logic [CW-1:0] bounce_count;
    logic [1:0]    state_dbg;

    logic [W-1:0] exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;
    int mon_idx      = 0;

    always #5 clk = ~clk;

    led_bar_decoder #(.SCREEN_WIDTH(SW), .BAR_WIDTH(BW), .COUNT_WIDTH(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample      (sample),
        .screen      (screen),
        .position    (position),
        .direction   (direction),
        .locked      (locked),
        .frame_error (frame_error),
        .bounce_count(bounce_count),
        .state_dbg   (state_dbg)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [SW-1:0] scr, input logic [PW-1:0] pos,
                         input logic dir, input logic lck, input logic err, input logic [CW-1:0] bc);
        @(negedge clk);
        sample = s;
        screen = scr;
        exp_q.push_back({pos, dir, lck, err, bc});
    endtask

    task automatic frame(input logic [SW-1:0] scr, input logic [PW-1:0] pos, input logic dir,
                         input logic lck, input logic err, input logic [CW-1:0] bc);
        drive(1'b1, scr, pos, dir, lck, err, bc);
    endtask

    task automatic drain();
        @(negedge clk);
        sample = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_position"}, 16'(position), 16'd0);
        check({tag, "_direction"}, 16'(direction), 16'd1);
        check({tag, "_locked"}, 16'(locked), 16'd0);
        check({tag, "_frame_error"}, 16'(frame_error), 16'd0);
        check({tag, "_bounce_count"}, 16'(bounce_count), 16'd0);
        check({tag, "_state"}, 16'(state_dbg), 16'd0);
    endtask

    // Outputs settle one cycle after the sampling edge; compare just after it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            mon_idx++;
            check($sformatf("step%0d", mon_idx),
                  16'({position, direction, locked, frame_error, bounce_count}), 16'(e));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        sample = 1'b0;
        screen = '0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        // Acquire, then a skipped position forces re-sync.
        frame(8'h07, 4'd2, 1'b1, 1'b0, 1'b0, 8'd0);
        frame(8'h0E, 4'd3, 1'b1, 1'b1, 1'b0, 8'd0);
        frame(8'h38, 4'd5, 1'b1, 1'b0, 1'b1, 8'd0);
        frame(8'h70, 4'd6, 1'b1, 1'b1, 1'b0, 8'd0);

        // Top bounce.
        frame(8'hE0, 4'd7, 1'b1, 1'b1, 1'b0, 8'd0);
`ifdef LED_BAR_DECODER_LATE_TURNAROUND_EN
        frame(8'hC0, 4'd8, 1'b1, 1'b1, 1'b0, 8'd0);
        frame(8'h80, 4'd9, 1'b1, 1'b1, 1'b0, 8'd0);
        frame(8'hC0, 4'd8, 1'b0, 1'b1, 1'b0, 8'd1);
        frame(8'hE0, 4'd7, 1'b0, 1'b1, 1'b0, 8'd1);
`endif
        frame(8'h70, 4'd6, 1'b0, 1'b1, 1'b0, 8'd1);
        frame(8'h38, 4'd5, 1'b0, 1'b1, 1'b0, 8'd1);

        // Hold on repeated frames, then idle cycles with junk on the screen.
        for (int i = 0; i < 5; i++) frame(8'h1C, 4'd4, 1'b0, 1'b1, 1'b0, 8'd1);
        for (int i = 0; i < 10; i++)
            drive(1'b0, SW'($urandom_range(0, 255)), 4'd4, 1'b0, 1'b1, 1'b0, 8'd1);

        // Illegal frame drops lock for one error cycle, then re-acquire downward.
        frame(8'h2C, 4'd4, 1'b0, 1'b0, 1'b1, 8'd1);
        frame(8'h38, 4'd5, 1'b0, 1'b0, 1'b0, 8'd1);
        frame(8'h1C, 4'd4, 1'b0, 1'b1, 1'b0, 8'd1);
        frame(8'h0E, 4'd3, 1'b0, 1'b1, 1'b0, 8'd1);
        frame(8'h07, 4'd2, 1'b0, 1'b1, 1'b0, 8'd1);
`ifdef LED_BAR_DECODER_LATE_TURNAROUND_EN
        frame(8'h03, 4'd1, 1'b0, 1'b1, 1'b0, 8'd1);
        frame(8'h01, 4'd0, 1'b0, 1'b1, 1'b0, 8'd1);
        frame(8'h03, 4'd1, 1'b1, 1'b1, 1'b0, 8'd2);
        frame(8'h07, 4'd2, 1'b1, 1'b1, 1'b0, 8'd2);
        frame(8'h0E, 4'd3, 1'b1, 1'b1, 1'b0, 8'd2);
`else
        frame(8'h0E, 4'd3, 1'b1, 1'b1, 1'b0, 8'd2);
`endif

        // Climb to the top edge, then present a clipped bar.
        frame(8'h1C, 4'd4, 1'b1, 1'b1, 1'b0, 8'd2);
        frame(8'h38, 4'd5, 1'b1, 1'b1, 1'b0, 8'd2);
        frame(8'h70, 4'd6, 1'b1, 1'b1, 1'b0, 8'd2);
        frame(8'hE0, 4'd7, 1'b1, 1'b1, 1'b0, 8'd2);
`ifdef LED_BAR_DECODER_LATE_TURNAROUND_EN
        frame(8'hC0, 4'd8, 1'b1, 1'b1, 1'b0, 8'd2);
        frame(8'h80, 4'd9, 1'b1, 1'b1, 1'b0, 8'd2);
        frame(8'hC0, 4'd8, 1'b0, 1'b1, 1'b0, 8'd3);
`else
        frame(8'hC0, 4'd7, 1'b1, 1'b0, 1'b1, 8'd2);
        frame(8'hE0, 4'd7, 1'b1, 1'b0, 1'b0, 8'd2);
        frame(8'h70, 4'd6, 1'b0, 1'b1, 1'b0, 8'd2);
`endif
        drain();

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        reset = 1'b0;
        frame(8'h38, 4'd5, 1'b1, 1'b0, 1'b0, 8'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/led_bar_decoder.md
# led_bar_decoder

Receive-side counterpart of the LED scanner bar. Samples a bar display vector on strobe, decodes the bar's position, and tracks direction and bounces. Checks every sampled frame against the legal bouncing-bar sequence and flags violations. Used as the scoreboard/monitor for scanner outputs and as a decoder for externally captured LED bars.

## Interface
- SCREEN_WIDTH, 8: number of display bits; bit 0 is the start edge.
- BAR_WIDTH, 3: lit bar width; legal range 1 <= BAR_WIDTH < SCREEN_WIDTH.
- COUNT_WIDTH, 8: width of bounce counter.
- POS_W (localparam) = $clog2(SCREEN_WIDTH+BAR_WIDTH).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- sample  in  1  frame strobe; screen is decoded on cycles where high.
- screen  in  SCREEN_WIDTH  display vector, 1 = lit.
- position  out  POS_W  virtual head index t of last legal frame.
- direction  out  1  1 = head index increasing, 0 = decreasing.
- locked  out  1  high in LOCKED state.
- frame_error  out  1  one-cycle pulse for an illegal or out-of-sequence frame.
- bounce_count  out  COUNT_WIDTH  turnarounds seen while locked; wraps modulo 2^COUNT_WIDTH.

## Operation
- Virtual coordinates: bar occupies bits t-BAR_WIDTH+1..t. Lit run of length L:
  - L == BAR_WIDTH: t = highest lit index.
  - clipped at bit 0 (L < BAR_WIDTH, late mode only): t = L-1.
  - clipped at top (L < BAR_WIDTH, late mode only): t = SCREEN_WIDTH-1+BAR_WIDTH-L.
- Legal frame: nonzero, single contiguous run, length and clipping accepted by current mode.
- Extremes: normal T_MIN = BAR_WIDTH-1, T_MAX = SCREEN_WIDTH-1; late T_MIN = 0, T_MAX = SCREEN_WIDTH+BAR_WIDTH-2.
- Expected successor in LOCKED: t+1 if direction=1, else t-1. At T_MAX the expected successor is t-1, with direction cleared. At T_MIN it is t+1, with direction set. Each accepted flip increments bounce_count.
- Same t as stored is a hold: accepted, nothing changes, no error.
- States and transitions are evaluated only on cycles with sample=1:
  - IDLE:
    - legal frame -> SYNC, store t.
    - illegal frame -> IDLE, error.
  - SYNC:
    - legal t' = t±1 -> LOCKED; store t'; direction = (t' > t).
    - legal, other t' -> SYNC, store t', error.
    - illegal frame -> IDLE, error.
  - LOCKED:
    - expected successor -> LOCKED, update t and direction.
    - legal, other t' -> SYNC, store t', error.
    - illegal frame -> IDLE, error; position and direction hold.
- bounce_count is cleared only by reset; it is retained across lock loss.

## Timing
- Reset values: state IDLE, position 0, direction 1, locked 0, frame_error 0, bounce_count 0.
- All outputs are registered. A frame sampled at edge N is reflected in outputs after edge N, with one-cycle latency.
- frame_error is high for exactly the cycle following an erroring sample. It is low after any non-erroring or sample=0 cycle.
- Back-to-back samples on every cycle are supported at full rate.
- sample=0: the screen value is ignored and all state holds.
- Reset asserted mid-operation: all outputs go to reset values immediately, with no clock needed. The first sample after release is treated as from IDLE.

## Configuration
- LED_BAR_DECODER_LATE_TURNAROUND_EN defined: clipped bars touching bit 0 or bit SCREEN_WIDTH-1 (1 <= L < BAR_WIDTH) are legal. Late-mode extremes apply; the turnaround occurs at a single lit LED.
- Not defined: only full-width runs are legal, and normal extremes apply. Clipped runs are illegal frames.

## Test plan
- Acquire, SCREEN_WIDTH=8, BAR_WIDTH=3:
  - sample 8'b00000111 -> position 2, locked 0.
  - then 8'b00001110 -> position 3, direction 1, locked 1, frame_error 0.
- Bounce: locked rising, frames 8'b11100000 then 8'b01110000 -> position 7 then 6, direction 0, bounce_count +1, no error.
- Hold and idle: repeat 8'b00011100 for 5 samples, then sample=0 for 10 cycles with garbage screen -> outputs unchanged, frame_error never high.
- Illegal frame while locked: 8'b00101100 -> frame_error high exactly 1 cycle, locked 0, position held. Next 8'b00111000 -> SYNC, position 5.
- Skip: locked at t=3 rising, then 8'b00111000 -> error, locked 0, position 5. Then 8'b01110000 -> locked 1, direction 1.
- Macro and reset:
  - With macro, locked at t=7 rising, 8'b11000000 -> position 8, no error.
  - Without macro, the same frame -> error, IDLE.
  - Async reset pulse between clock edges -> all outputs reset immediately.
